// File: rtl/cv32e40s_integrity_alert_handler_if.sv
// Interface between the hardening checkers/controller and the integrity alert handler.
// Handshake: the handler holds nmi_req_o high from the cycle after a major event until
// the controller answers with a one-cycle nmi_ack_i pulse; an ack while no request is
// pending has no effect, and an ack coinciding with a fresh major event keeps the request up.
interface cv32e40s_integrity_alert_handler_if;
    logic       pc_err_i;
    logic       csr_err_i;
    logic       rf_ecc_err_i;
    logic       itf_int_err_i;
    logic       lfsr_lockup_i;
    logic       bus_fault_i;
    logic       nmi_ack_i;
    logic [5:0] cause_clr_i;
    logic       alert_major_o;
    logic       alert_minor_o;
    logic       nmi_req_o;
    logic       lockup_o;
    logic [5:0] err_cause_o;
    logic [1:0] dbg_state_o;

    // Checker/controller side
    modport master (
        output pc_err_i, csr_err_i, rf_ecc_err_i, itf_int_err_i,
        output lfsr_lockup_i, bus_fault_i, nmi_ack_i, cause_clr_i,
        input  alert_major_o, alert_minor_o, nmi_req_o, lockup_o, err_cause_o, dbg_state_o
    );

    // Alert handler side
    modport slave (
        input  pc_err_i, csr_err_i, rf_ecc_err_i, itf_int_err_i,
        input  lfsr_lockup_i, bus_fault_i, nmi_ack_i, cause_clr_i,
        output alert_major_o, alert_minor_o, nmi_req_o, lockup_o, err_cause_o, dbg_state_o
    );
endinterface

// File: rtl/cv32e40s_integrity_alert_handler.sv
// Integrity alert handler: classifies checker errors into major/minor alerts, escalates
// bursts of minor events within an observation window, requests an NMI and locks the
// core after repeated major alerts. Every output is decoded from flops.
module cv32e40s_integrity_alert_handler #(
    parameter int unsigned MINOR_THRESHOLD = 4,
    parameter int unsigned WINDOW_CYCLES   = 1024,
    parameter int unsigned MAJOR_LOCK      = 3
) (
    input logic                                clk,
    input logic                                rst_n,
    cv32e40s_integrity_alert_handler_if.slave  bus
);

    localparam int unsigned WW  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned MNW = $clog2(MINOR_THRESHOLD + 1);
    localparam int unsigned MJW = $clog2(MAJOR_LOCK + 1);

    localparam logic [WW-1:0]  WIN_LAST  = WW'(WINDOW_CYCLES - 1);
    localparam logic [MNW-1:0] MIN_LAST  = MNW'(MINOR_THRESHOLD - 1);
    localparam logic [MJW-1:0] MAJ_LIMIT = MJW'(MAJOR_LOCK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        LOCK = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [WW-1:0]  win_cnt_q, win_cnt_d;
    logic [MNW-1:0] minor_cnt_q, minor_cnt_d;
    logic [MJW-1:0] major_cnt_q, major_cnt_d;
    logic [5:0]     cause_q, cause_d;
    logic           alert_major_q, alert_major_d;
    logic           alert_minor_q, alert_minor_d;

    logic           major_in;
    logic           minor_in;
    logic           win_wrap;
    logic           escalate;
    logic           major_evt;
    logic [MNW-1:0] minor_base;

    // Event classification, minor-burst escalation, major counting and sticky causes
    always_comb begin
        major_in    = bus.pc_err_i | bus.csr_err_i | bus.rf_ecc_err_i | bus.itf_int_err_i;
        minor_in    = bus.lfsr_lockup_i | bus.bus_fault_i;
        win_wrap    = (win_cnt_q == WIN_LAST);
        win_cnt_d   = win_wrap ? '0 : win_cnt_q + 1'b1;
        // On the wrap cycle the old window's count is discarded, so a minor event
        // there is the first one of the new window.
        minor_base  = win_wrap ? '0 : minor_cnt_q;
        escalate    = 1'b0;
        minor_cnt_d = minor_base;
        if (minor_in) begin
            if (minor_base == MIN_LAST) begin
                escalate    = 1'b1;
                minor_cnt_d = '0;
            end else begin
                minor_cnt_d = minor_base + 1'b1;
            end
        end
        major_evt     = major_in | escalate;
        alert_major_d = major_evt;
        alert_minor_d = minor_in;
        // alert_major_q holds last cycle's major_evt, so this detects its rising edge.
        major_cnt_d = major_cnt_q;
        if (major_evt && !alert_major_q && (major_cnt_q != MAJ_LIMIT)) begin
            major_cnt_d = major_cnt_q + 1'b1;
        end
        // Set beats clear when both hit the same bit in one cycle.
        cause_d = (cause_q & ~bus.cause_clr_i) |
                  {escalate, minor_in, bus.itf_int_err_i, bus.rf_ecc_err_i,
                   bus.csr_err_i, bus.pc_err_i};
    end

    // NMI request / lockup state transitions
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (major_evt) state_d = PEND;
            PEND: if (bus.nmi_ack_i && !major_evt) state_d = IDLE;
            LOCK: state_d = LOCK;
            default: state_d = IDLE;
        endcase
        if (major_cnt_q == MAJ_LIMIT) begin
            state_d = LOCK;
        end
    end

    // State, counter, alert and cause registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            win_cnt_q     <= '0;
            minor_cnt_q   <= '0;
            major_cnt_q   <= '0;
            cause_q       <= '0;
            alert_major_q <= 1'b0;
            alert_minor_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            win_cnt_q     <= win_cnt_d;
            minor_cnt_q   <= minor_cnt_d;
            major_cnt_q   <= major_cnt_d;
            cause_q       <= cause_d;
            alert_major_q <= alert_major_d;
            alert_minor_q <= alert_minor_d;
        end
    end

    assign bus.alert_major_o = alert_major_q;
    assign bus.alert_minor_o = alert_minor_q;
    assign bus.nmi_req_o     = (state_q == PEND);
    assign bus.lockup_o      = (state_q == LOCK);
    assign bus.err_cause_o   = cause_q;
    assign bus.dbg_state_o   = state_q;

endmodule

// File: tb/tb_cv32e40s_integrity_alert_handler.sv
// Directed testbench for the integrity alert handler (default parameters).
module tb_cv32e40s_integrity_alert_handler;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    int   win_pos;

    cv32e40s_integrity_alert_handler_if ifc ();

    cv32e40s_integrity_alert_handler #(
        .MINOR_THRESHOLD (4),
        .WINDOW_CYCLES   (1024),
        .MAJOR_LOCK      (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs set before a call are sampled at window cycle win_pos.
    task automatic tick();
        @(posedge clk);
        #1;
        win_pos++;
    endtask

    task automatic clear_inputs();
        ifc.pc_err_i      = 1'b0;
        ifc.csr_err_i     = 1'b0;
        ifc.rf_ecc_err_i  = 1'b0;
        ifc.itf_int_err_i = 1'b0;
        ifc.lfsr_lockup_i = 1'b0;
        ifc.bus_fault_i   = 1'b0;
        ifc.nmi_ack_i     = 1'b0;
        ifc.cause_clr_i   = 6'h00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        win_pos = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ifc.alert_major_o, ifc.alert_minor_o, ifc.nmi_req_o, ifc.lockup_o} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000",
                     {ifc.alert_major_o, ifc.alert_minor_o, ifc.nmi_req_o, ifc.lockup_o});
            n_fails++;
        end
        n_checks++;
        if (ifc.err_cause_o !== 6'b000000) begin
            $display("FAIL reset_cause: got %b expected 000000", ifc.err_cause_o);
            n_fails++;
        end
        n_checks++;
        if (ifc.dbg_state_o !== 2'd0) begin
            $display("FAIL reset_state: got %0d expected 0", ifc.dbg_state_o);
            n_fails++;
        end
    endtask

    task automatic test_pc_nmi();
        do_reset();
        ifc.pc_err_i = 1'b1;
        tick();                               // cycle t0 sampled
        ifc.pc_err_i = 1'b0;
        n_checks++;
        if ({ifc.alert_major_o, ifc.nmi_req_o} !== 2'b11) begin
            $display("FAIL pc_alert_nmi: got %b expected 11", {ifc.alert_major_o, ifc.nmi_req_o});
            n_fails++;
        end
        n_checks++;
        if (ifc.err_cause_o !== 6'b000001) begin
            $display("FAIL pc_cause: got %b expected 000001", ifc.err_cause_o);
            n_fails++;
        end
        tick();                               // now t0+2
        n_checks++;
        if ({ifc.alert_major_o, ifc.nmi_req_o} !== 2'b01) begin
            $display("FAIL pc_held: got %b expected 01", {ifc.alert_major_o, ifc.nmi_req_o});
            n_fails++;
        end
        tick();                               // now t0+3
        ifc.nmi_ack_i = 1'b1;
        tick();                               // now t0+4
        ifc.nmi_ack_i = 1'b0;
        n_checks++;
        if (ifc.nmi_req_o !== 1'b0) begin
            $display("FAIL pc_ack_release: got %b expected 0", ifc.nmi_req_o);
            n_fails++;
        end
        ifc.nmi_ack_i = 1'b1;                 // ack with nothing pending
        tick();
        ifc.nmi_ack_i = 1'b0;
        n_checks++;
        if ({ifc.nmi_req_o, ifc.dbg_state_o} !== 3'b000) begin
            $display("FAIL idle_ack_ignored: got %b expected 000", {ifc.nmi_req_o, ifc.dbg_state_o});
            n_fails++;
        end
    endtask

    task automatic test_escalation();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ifc.bus_fault_i = 1'b1;
            tick();
            ifc.bus_fault_i = 1'b0;
            tick();
        end
        n_checks++;
        if ({ifc.alert_major_o, ifc.err_cause_o[5], ifc.nmi_req_o} !== 3'b000) begin
            $display("FAIL esc_before_4th: got %b expected 000",
                     {ifc.alert_major_o, ifc.err_cause_o[5], ifc.nmi_req_o});
            n_fails++;
        end
        ifc.bus_fault_i = 1'b1;
        tick();
        ifc.bus_fault_i = 1'b0;
        n_checks++;
        if ({ifc.alert_major_o, ifc.alert_minor_o, ifc.nmi_req_o} !== 3'b111) begin
            $display("FAIL esc_alert: got %b expected 111",
                     {ifc.alert_major_o, ifc.alert_minor_o, ifc.nmi_req_o});
            n_fails++;
        end
        n_checks++;
        if (ifc.err_cause_o !== 6'b110000) begin
            $display("FAIL esc_cause: got %b expected 110000", ifc.err_cause_o);
            n_fails++;
        end
    endtask

    task automatic test_window_wrap();
        logic saw_major;
        do_reset();
        saw_major = 1'b0;
        while (win_pos < 1020) tick();
        ifc.bus_fault_i = 1'b1;
        while (win_pos < 1023) begin
            tick();
            saw_major |= ifc.alert_major_o;
        end
        ifc.bus_fault_i = 1'b0;
        while (win_pos < 1024 + 5) begin
            tick();
            saw_major |= ifc.alert_major_o;
        end
        ifc.bus_fault_i = 1'b1;
        tick();
        ifc.bus_fault_i = 1'b0;
        saw_major |= ifc.alert_major_o;
        n_checks++;
        if (ifc.alert_minor_o !== 1'b1) begin
            $display("FAIL wrap_minor_seen: got %b expected 1", ifc.alert_minor_o);
            n_fails++;
        end
        tick();
        saw_major |= ifc.alert_major_o;
        n_checks++;
        if ({saw_major, ifc.err_cause_o[5], ifc.nmi_req_o} !== 3'b000) begin
            $display("FAIL wrap_no_escalate: got %b expected 000",
                     {saw_major, ifc.err_cause_o[5], ifc.nmi_req_o});
            n_fails++;
        end
    endtask

    task automatic test_lockup();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            ifc.csr_err_i = 1'b1;
            tick();
            ifc.csr_err_i = 1'b0;
            ifc.nmi_ack_i = 1'b1;
            tick();
            ifc.nmi_ack_i = 1'b0;
            tick();
        end
        n_checks++;
        if ({ifc.lockup_o, ifc.nmi_req_o} !== 2'b00) begin
            $display("FAIL lock_after_two: got %b expected 00", {ifc.lockup_o, ifc.nmi_req_o});
            n_fails++;
        end
        ifc.csr_err_i = 1'b1;
        tick();
        ifc.csr_err_i = 1'b0;
        n_checks++;
        if ({ifc.alert_major_o, ifc.lockup_o} !== 2'b10) begin
            $display("FAIL lock_third_alert: got %b expected 10", {ifc.alert_major_o, ifc.lockup_o});
            n_fails++;
        end
        tick();
        n_checks++;
        if ({ifc.lockup_o, ifc.nmi_req_o, ifc.dbg_state_o} !== 4'b1010) begin
            $display("FAIL lock_entered: got %b expected 1010",
                     {ifc.lockup_o, ifc.nmi_req_o, ifc.dbg_state_o});
            n_fails++;
        end
        ifc.nmi_ack_i = 1'b1;
        ifc.pc_err_i  = 1'b1;
        tick();
        ifc.nmi_ack_i = 1'b0;
        ifc.pc_err_i  = 1'b0;
        tick();
        n_checks++;
        if ({ifc.lockup_o, ifc.nmi_req_o, ifc.err_cause_o[0]} !== 3'b101) begin
            $display("FAIL lock_sticky: got %b expected 101",
                     {ifc.lockup_o, ifc.nmi_req_o, ifc.err_cause_o[0]});
            n_fails++;
        end
        // Asynchronous reset in the middle of a cycle
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ifc.alert_major_o, ifc.alert_minor_o, ifc.nmi_req_o, ifc.lockup_o, ifc.err_cause_o}
            !== 10'b0) begin
            $display("FAIL lock_async_reset: got %b expected 0000000000",
                     {ifc.alert_major_o, ifc.alert_minor_o, ifc.nmi_req_o, ifc.lockup_o,
                      ifc.err_cause_o});
            n_fails++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({ifc.lockup_o, ifc.dbg_state_o} !== 3'b000) begin
            $display("FAIL lock_release_idle: got %b expected 000", {ifc.lockup_o, ifc.dbg_state_o});
            n_fails++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ifc.pc_err_i = 1'b1;
        tick();
        ifc.pc_err_i     = 1'b0;
        tick();
        ifc.rf_ecc_err_i = 1'b1;
        ifc.nmi_ack_i    = 1'b1;
        tick();
        ifc.rf_ecc_err_i = 1'b0;
        ifc.nmi_ack_i    = 1'b0;
        n_checks++;
        if ({ifc.nmi_req_o, ifc.err_cause_o[2], ifc.alert_major_o} !== 3'b111) begin
            $display("FAIL b2b_pend_kept: got %b expected 111",
                     {ifc.nmi_req_o, ifc.err_cause_o[2], ifc.alert_major_o});
            n_fails++;
        end
        ifc.nmi_ack_i = 1'b1;
        tick();
        ifc.nmi_ack_i = 1'b0;
        n_checks++;
        if (ifc.nmi_req_o !== 1'b0) begin
            $display("FAIL b2b_second_ack: got %b expected 0", ifc.nmi_req_o);
            n_fails++;
        end
    endtask

    task automatic test_cause_clear();
        do_reset();
        ifc.pc_err_i    = 1'b1;
        ifc.bus_fault_i = 1'b1;
        tick();
        ifc.pc_err_i    = 1'b0;
        ifc.bus_fault_i = 1'b0;
        n_checks++;
        if (ifc.err_cause_o !== 6'b010001) begin
            $display("FAIL clr_preset: got %b expected 010001", ifc.err_cause_o);
            n_fails++;
        end
        ifc.cause_clr_i   = 6'h3F;
        ifc.itf_int_err_i = 1'b1;
        tick();
        ifc.cause_clr_i   = 6'h00;
        ifc.itf_int_err_i = 1'b0;
        n_checks++;
        if (ifc.err_cause_o !== 6'b001000) begin
            $display("FAIL clr_set_wins: got %b expected 001000", ifc.err_cause_o);
            n_fails++;
        end
        tick();
        tick();
        n_checks++;
        if (ifc.err_cause_o !== 6'b001000) begin
            $display("FAIL clr_sticky: got %b expected 001000", ifc.err_cause_o);
            n_fails++;
        end
        ifc.cause_clr_i = 6'b001000;
        tick();
        ifc.cause_clr_i = 6'h00;
        n_checks++;
        if (ifc.err_cause_o !== 6'b000000) begin
            $display("FAIL clr_single_bit: got %b expected 000000", ifc.err_cause_o);
            n_fails++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        win_pos  = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_pc_nmi();
        test_escalation();
        test_window_wrap();
        test_lockup();
        test_back_to_back();
        test_cause_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
